// File: rtl/pc_target_table.sv
// pc_target_table: programmable branch-target table.
// Holds DEPTH entries of {valid, target}. A write port loads or invalidates
// entries, a registered lookup port answers every request one cycle later
// with hit/target. The storage array has no reset, so a clear sequencer
// walks it after every reset before writes are accepted.
module pc_target_table #(
    parameter int unsigned    D           = 12,
    parameter int unsigned    AW          = 8,
    parameter int unsigned    DEPTH       = 32,
    parameter logic [D-1:0]   MISS_TARGET = {D{1'b0}}
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_inval,
    output logic          wr_ready,
    output logic          wr_err,
    input  logic          lk_req,
    input  logic [AW-1:0] lk_addr,
    output logic          lk_ack,
    output logic          lk_hit,
    output logic [D-1:0]  lk_target,
    output logic          busy
);

    localparam int unsigned   CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
    // One extra bit so DEPTH == 2**AW is representable in the range check.
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   clr_idx_q;
    logic            wr_err_q;
    logic            lk_ack_q;
    logic            lk_hit_q;
    logic [D-1:0]    lk_target_q;

    // Storage word layout: bit D is the valid flag, bits D-1:0 the target.
    logic [D:0]      mem_q [DEPTH];

    logic            wr_in_range_s;
    logic            lk_in_range_s;
    logic            wr_accept_s;
    logic            wr_reject_s;
    logic [D:0]      wr_word_s;
    logic            mem_we_s;
    logic [CW-1:0]   mem_waddr_s;
    logic [D:0]      mem_wdata_s;
    logic [D:0]      rd_word_s;
    logic            lk_hit_s;
    logic [D-1:0]    lk_target_s;
    logic [CW-1:0]   clr_idx_d;

    // Decode write acceptance, memory write port mux and the lookup result.
    always_comb begin
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_W);
        lk_in_range_s = ({1'b0, lk_addr} < DEPTH_W);
        wr_accept_s   = wr_en && (state_q == ST_READY) && wr_in_range_s;
        wr_reject_s   = wr_en && !wr_accept_s;

        if (wr_inval) begin
            wr_word_s = {1'b0, MISS_TARGET};
        end else begin
            wr_word_s = {1'b1, wr_data};
        end

        // The clear sequencer owns the write port while in CLEAR.
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_q;
            mem_wdata_s = {1'b0, MISS_TARGET};
        end else begin
            mem_we_s    = wr_accept_s;
            mem_waddr_s = wr_addr[CW-1:0];
            mem_wdata_s = wr_word_s;
        end

        // Write-first bypass when an accepted write hits the looked-up entry.
        if (wr_accept_s && (wr_addr == lk_addr)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem_q[lk_addr[CW-1:0]];
        end

        lk_hit_s = (state_q == ST_READY) && lk_in_range_s && rd_word_s[D];
        if (lk_hit_s) begin
            lk_target_s = rd_word_s[D-1:0];
        end else begin
            lk_target_s = MISS_TARGET;
        end

        // Clear index saturates at the last entry instead of wrapping.
        if (clr_idx_q == LAST_IDX) begin
            clr_idx_d = clr_idx_q;
        end else begin
            clr_idx_d = clr_idx_q + CW'(1);
        end
    end

    // Storage array write port; intentionally without reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Clear/ready sequencer and registered write-error and lookup outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= {CW{1'b0}};
            wr_err_q    <= 1'b0;
            lk_ack_q    <= 1'b0;
            lk_hit_q    <= 1'b0;
            lk_target_q <= {D{1'b0}};
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_d;
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= ST_READY;
                    end else begin
                        state_q <= ST_CLEAR;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_idx_q <= {CW{1'b0}};
                end
            endcase

            wr_err_q <= wr_reject_s;
            lk_ack_q <= lk_req;
            // Hit/target hold their value between acks.
            if (lk_req) begin
                lk_hit_q    <= lk_hit_s;
                lk_target_q <= lk_target_s;
            end else begin
                lk_hit_q    <= lk_hit_q;
                lk_target_q <= lk_target_q;
            end
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign wr_ready  = (state_q == ST_READY);
    assign wr_err    = wr_err_q;
    assign lk_ack    = lk_ack_q;
    assign lk_hit    = lk_hit_q;
    assign lk_target = lk_target_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Directed testbench for pc_target_table: a default instance (D=12, AW=8,
// DEPTH=32, MISS_TARGET=0) and a narrow instance (D=16, AW=4, DEPTH=16,
// MISS_TARGET=0x1234) share clock and reset. Expected lookup results come
// from a behavioural table model and are queued at request time, then
// popped when the ack is due.
module tb_pc_target_table;

    logic clk = 1'b0;
    logic reset_n;

    logic        wr_en_a, wr_inval_a, lk_req_a;
    logic [7:0]  wr_addr_a, lk_addr_a;
    logic [11:0] wr_data_a;
    logic        wr_ready_a, wr_err_a, lk_ack_a, lk_hit_a, busy_a;
    logic [11:0] lk_target_a;

    logic        wr_en_b, wr_inval_b, lk_req_b;
    logic [3:0]  wr_addr_b, lk_addr_b;
    logic [15:0] wr_data_b;
    logic        wr_ready_b, wr_err_b, lk_ack_b, lk_hit_b, busy_b;
    logic [15:0] lk_target_b;

    int tests = 0;
    int fails = 0;

    // Bench model of both tables.
    logic        mv_a [32];
    logic [11:0] md_a [32];
    logic        rdy_a;
    logic        mv_b [16];
    logic [15:0] md_b [16];
    logic        rdy_b;
    logic [16:0] q_a [$];
    logic [16:0] q_b [$];

    pc_target_table #(.D(12), .AW(8), .DEPTH(32), .MISS_TARGET(12'h000)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_inval(wr_inval_a),
        .wr_ready(wr_ready_a), .wr_err(wr_err_a),
        .lk_req(lk_req_a), .lk_addr(lk_addr_a),
        .lk_ack(lk_ack_a), .lk_hit(lk_hit_a), .lk_target(lk_target_a),
        .busy(busy_a)
    );

    pc_target_table #(.D(16), .AW(4), .DEPTH(16), .MISS_TARGET(16'h1234)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_inval(wr_inval_b),
        .wr_ready(wr_ready_b), .wr_err(wr_err_b),
        .lk_req(lk_req_b), .lk_addr(lk_addr_b),
        .lk_ack(lk_ack_b), .lk_hit(lk_hit_b), .lk_target(lk_target_b),
        .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en_a = 1'b0; wr_inval_a = 1'b0; wr_addr_a = 8'd0; wr_data_a = 12'd0;
        lk_req_a = 1'b0; lk_addr_a = 8'd0;
        wr_en_b = 1'b0; wr_inval_b = 1'b0; wr_addr_b = 4'd0; wr_data_b = 16'd0;
        lk_req_b = 1'b0; lk_addr_b = 4'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin mv_a[i] = 1'b0; md_a[i] = 12'd0; end
        for (int i = 0; i < 16; i++) begin mv_b[i] = 1'b0; md_b[i] = 16'd0; end
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        q_a.delete();
        q_b.delete();
    endtask

    // Apply one clock: update model, queue expected lookups, check after edge.
    task automatic tick();
        logic ra, rb, ea, eb, acc, hit;
        logic [16:0] e;
        ra = lk_req_a;
        rb = lk_req_b;

        acc = wr_en_a && rdy_a && (wr_addr_a < 8'd32);
        ea  = wr_en_a && !acc;
        if (acc) begin
            mv_a[wr_addr_a[4:0]] = !wr_inval_a;
            md_a[wr_addr_a[4:0]] = wr_inval_a ? 12'd0 : wr_data_a;
        end
        if (ra) begin
            hit = rdy_a && (lk_addr_a < 8'd32) && mv_a[lk_addr_a[4:0]];
            q_a.push_back({hit, 4'd0, hit ? md_a[lk_addr_a[4:0]] : 12'd0});
        end

        acc = wr_en_b && rdy_b;
        eb  = wr_en_b && !acc;
        if (acc) begin
            mv_b[wr_addr_b] = !wr_inval_b;
            md_b[wr_addr_b] = wr_inval_b ? 16'h1234 : wr_data_b;
        end
        if (rb) begin
            hit = rdy_b && mv_b[lk_addr_b];
            q_b.push_back({hit, hit ? md_b[lk_addr_b] : 16'h1234});
        end

        @(posedge clk);
        #1;
        chk("ack_a", 32'(lk_ack_a), 32'(ra));
        chk("err_a", 32'(wr_err_a), 32'(ea));
        if (ra) begin
            e = q_a.pop_front();
            chk("hit_a", 32'(lk_hit_a), 32'(e[16]));
            chk("tgt_a", 32'(lk_target_a), 32'(e[11:0]));
        end
        chk("ack_b", 32'(lk_ack_b), 32'(rb));
        chk("err_b", 32'(wr_err_b), 32'(eb));
        if (rb) begin
            e = q_b.pop_front();
            chk("hit_b", 32'(lk_hit_b), 32'(e[16]));
            chk("tgt_b", 32'(lk_target_b), 32'(e[15:0]));
        end
    endtask

    // Run the 32-cycle clear right after reset release; probes lookups and
    // rejected writes during CLEAR and checks busy/ready edges exactly.
    task automatic clear_phase(input logic [7:0] probe_a);
        for (int i = 0; i < 32; i++) begin
            idle();
            if (i == 0) begin
                lk_req_a = 1'b1; lk_addr_a = probe_a;
                lk_req_b = 1'b1; lk_addr_b = 4'd3;
            end
            if (i == 1) begin
                wr_en_a = 1'b1; wr_addr_a = 8'd3; wr_data_a = 12'd99;
                wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_data_b = 16'd1;
            end
            tick();
            chk("busy_a", 32'(busy_a), 32'(i < 31));
            chk("ready_a", 32'(wr_ready_a), 32'(i >= 31));
            chk("busy_b", 32'(busy_b), 32'(i < 15));
            if (i == 15) rdy_b = 1'b1;
            if (i == 31) rdy_a = 1'b1;
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_ready_a", 32'(wr_ready_a), 32'd0);
        chk("rst_err_a", 32'(wr_err_a), 32'd0);
        chk("rst_ack_a", 32'(lk_ack_a), 32'd0);
        chk("rst_hit_a", 32'(lk_hit_a), 32'd0);
        chk("rst_tgt_a", 32'(lk_target_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_tgt_b", 32'(lk_target_b), 32'd0);

        reset_n = 1'b1;
        clear_phase(8'd5);

        // First READY cycle: write made during CLEAR must not be visible.
        lk_req_a = 1'b1; lk_addr_a = 8'd3; tick(); idle();

        // Load four entries, then back-to-back lookups plus an unwritten entry.
        wr_en_a = 1'b1;
        wr_addr_a = 8'd0; wr_data_a = 12'd7;   tick();
        wr_addr_a = 8'd1; wr_data_a = 12'd6;   tick();
        wr_addr_a = 8'd2; wr_data_a = 12'd503; tick();
        wr_addr_a = 8'd3; wr_data_a = 12'd328; tick();
        idle();
        lk_req_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lk_addr_a = 8'(i);
            tick();
        end
        idle();

        // Read-during-write bypass, hold between acks, then invalidate bypass.
        wr_en_a = 1'b1; wr_addr_a = 8'd9; wr_data_a = 12'd231;
        lk_req_a = 1'b1; lk_addr_a = 8'd9; tick(); idle();
        tick();
        chk("hold_hit_a", 32'(lk_hit_a), 32'd1);
        chk("hold_tgt_a", 32'(lk_target_a), 32'd231);
        wr_en_a = 1'b1; wr_inval_a = 1'b1; wr_addr_a = 8'd9; wr_data_a = 12'd77;
        lk_req_a = 1'b1; lk_addr_a = 8'd9; tick(); idle();
        lk_req_a = 1'b1; lk_addr_a = 8'd9; tick(); idle();

        // Out-of-range write: error pulse of one cycle, no aliasing into entry 8.
        wr_en_a = 1'b1; wr_addr_a = 8'd40; wr_data_a = 12'd55; tick(); idle();
        tick();
        lk_req_a = 1'b1; lk_addr_a = 8'd8;  tick();
        lk_addr_a = 8'd40; tick();
        lk_addr_a = 8'd255; tick(); idle();

        // Independent write and lookup to different entries.
        wr_en_a = 1'b1; wr_addr_a = 8'd10; wr_data_a = 12'd100;
        lk_req_a = 1'b1; lk_addr_a = 8'd0; tick(); idle();
        lk_req_a = 1'b1; lk_addr_a = 8'd10; tick(); idle();

        // Narrow instance: full-width data in the last entry, miss target.
        wr_en_b = 1'b1; wr_addr_b = 4'd15; wr_data_b = 16'hFFFF; tick(); idle();
        lk_req_b = 1'b1; lk_addr_b = 4'd15; tick();
        lk_addr_b = 4'd7; tick(); idle();

        // Reset while an ack is showing and another request is pending.
        lk_req_a = 1'b1; lk_addr_a = 8'd2; tick();
        lk_addr_a = 8'd1;
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_ack_a", 32'(lk_ack_a), 32'd0);
        chk("mid_hit_a", 32'(lk_hit_a), 32'd0);
        chk("mid_tgt_a", 32'(lk_target_a), 32'd0);
        chk("mid_busy_a", 32'(busy_a), 32'd1);
        chk("mid_ready_a", 32'(wr_ready_a), 32'd0);
        idle();
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_phase(8'd2);
        lk_req_a = 1'b1; lk_addr_a = 8'd2; tick();
        lk_addr_a = 8'd0; tick(); idle();
        lk_req_b = 1'b1; lk_addr_b = 4'd15; tick(); idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
